// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction loader.
// ROM_SIZE is also the instruction memory depth.
package inst_mem_loader_pkg;

  localparam int ROM_SIZE   = 32;
  localparam int LEN_W      = 8;
  localparam int ADDR_SHIFT = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/inst_mem_loader_byte_to_word_packer.sv
// Packs big-endian bytes into 32-bit words.
// Emits a one-cycle word_valid the cycle after the 4th byte.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    vld_d  = 1'b0;
    word_d = word_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (byte_en_i) begin
      sh_d  = {sh_q[15:0], byte_i};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        word_d = {sh_q, byte_i};
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign last_o       = (cnt_q == 2'd3);
  assign word_valid_o = vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: framed byte stream (len, words, checksum) into instruction RAM.
// Holds the CPU in reset until a checksum-valid image is written.
module inst_mem_loader #(
  parameter int ROM_SIZE = inst_mem_loader_pkg::ROM_SIZE,
  parameter int LEN_W    = inst_mem_loader_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] word_count
);

  import inst_mem_loader_pkg::*;

  state_e state_q, state_d;

  logic [LEN_W-1:0] wc_q, wc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       cs_q, cs_d;

  logic        fire;
  logic        start_ok;
  logic        pk_last;
  logic        pk_vld;
  logic [31:0] pk_word;
  logic        len_bad;
  logic        last_word;

  assign fire      = byte_valid & byte_ready;
  assign start_ok  = start & ((state_q == ST_IDLE) |
                              (state_q == ST_DONE) |
                              (state_q == ST_ERR));
  assign len_bad   = (byte_data == 8'd0) |
                     (int'(byte_data) > ROM_SIZE);
  assign last_word = pk_last & ((wc_q + 1'b1) == len_q);

  byte_to_word_packer u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_ok),
    .byte_en_i    (fire & (state_q == ST_DATA)),
    .byte_i       (byte_data),
    .last_o       (pk_last),
    .word_valid_o (pk_vld),
    .word_o       (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LEN;
      ST_LEN: begin
        if (fire) state_d = len_bad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (fire && last_word) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (fire) state_d = (byte_data == cs_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: if (start) state_d = ST_LEN;
      ST_ERR:  if (start) state_d = ST_LEN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    unique case (state_q)
      ST_LEN, ST_DATA, ST_CHK: byte_ready = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  // The final word's write lands in the first CHK cycle, never in ERR.
  assign wr_en      = pk_vld & (state_q != ST_ERR);
  assign wr_data    = pk_word;
  assign wr_addr    = 32'(wc_q) << ADDR_SHIFT;
  assign word_count = wc_q;

  always_comb begin
    wc_d  = wc_q;
    len_d = len_q;
    cs_d  = cs_q;
    if (start_ok) begin
      wc_d = '0;
      cs_d = '0;
    end else begin
      if (fire && state_q == ST_LEN)  len_d = LEN_W'(byte_data);
      if (fire && state_q == ST_DATA) cs_d  = cs_q + byte_data;
      if (wr_en)                      wc_d  = wc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q  <= '0;
      len_q <= '0;
      cs_q  <= '0;
    end else begin
      wc_q  <= wc_d;
      len_q <= len_d;
      cs_q  <= cs_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: per-cycle vector table
// plus hand sequences for gaps and mid-load reset.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [7:0]  word_count;

  int checks   = 0;
  int failures = 0;

  int          wr_cnt = 0;
  logic [31:0] last_a = '0;
  logic [31:0] last_d = '0;

  always #5 clk = ~clk;

  inst_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt = wr_cnt + 1;
      last_a = wr_addr;
      last_d = wr_data;
    end
  end

  typedef struct {
    logic        st;
    logic        vl;
    logic [7:0]  dt;
    logic        rdy;
    logic        we;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        hd;
    logic        dn;
    logic        er;
    logic [7:0]  wc;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic st, input logic vl,
                   input logic [7:0] dt, input logic rdy,
                   input logic we, input logic [31:0] ad,
                   input logic [31:0] wd, input logic hd,
                   input logic dn, input logic er,
                   input logic [7:0] wc);
    vec_t e;
    e.st = st; e.vl = vl; e.dt = dt; e.rdy = rdy;
    e.we = we; e.ad = ad; e.wd = wd; e.hd = hd;
    e.dn = dn; e.er = er; e.wc = wc;
    vq.push_back(e);
  endtask

  // Two-word stream body (after start), ending in the post-checksum cycle.
  task automatic stream2(input logic [7:0] ck, input logic good);
    v(0, 1, 8'h02, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'h3c, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'h11, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'h40, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'h26, 1, 1, 32'h0, 32'h3c114000, 1, 0, 0, 0);
    v(0, 1, 8'h31, 1, 0, 0, 0, 1, 0, 0, 1);
    v(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1);
    v(0, 1, 8'h04, 1, 0, 0, 0, 1, 0, 0, 1);
    v(0, 1, ck,    1, 1, 32'h4, 32'h26310004, 1, 0, 0, 1);
    v(0, 0, 8'h00, 0, 0, 0, 0, !good, good, !good, 2);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Call at a negedge; returns at a negedge.
  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_two_word(input int gap);
    send(8'h02, gap); send(8'h3c, gap); send(8'h11, gap);
    send(8'h40, gap); send(8'h00, gap); send(8'h26, gap);
    send(8'h31, gap); send(8'h00, gap); send(8'h04, gap);
    send(8'hE8, gap);
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Good load, restart from DONE into a bad-checksum load
    v(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    stream2(8'hE8, 1'b1);
    v(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 2);
    stream2(8'hE9, 1'b0);
    v(0, 1, 8'h55, 0, 0, 0, 0, 1, 0, 1, 2);
    // Illegal lengths 0x00 and 0x21
    v(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 2);
    v(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
    v(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 1, 8'h21, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    // Start pulses during LEN/DATA/CHK are ignored
    v(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
    v(1, 1, 8'h24, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'h10, 1, 0, 0, 0, 1, 0, 0, 0);
    v(1, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);
    v(0, 1, 8'haa, 1, 0, 0, 0, 1, 0, 0, 0);
    v(1, 1, 8'hde, 1, 1, 32'h0, 32'h241000aa, 1, 0, 0, 0);
    v(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1);
    // Start in DONE clears done and returns to LEN
    v(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1);
    v(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0);

    #1;
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst ready", 32'(byte_ready), 0);
    chk("rst hold", 32'(cpu_hold), 1);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst wc", 32'(word_count), 0);
    chk("rst addr", wr_addr, 0);
    chk("rst data", wr_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start      = vq[i].st;
      byte_valid = vq[i].vl;
      byte_data  = vq[i].dt;
      #1;
      chk($sformatf("v%0d ready", i), 32'(byte_ready), 32'(vq[i].rdy));
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vq[i].we));
      chk($sformatf("v%0d hold", i), 32'(cpu_hold), 32'(vq[i].hd));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vq[i].dn));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vq[i].er));
      chk($sformatf("v%0d wc", i), 32'(word_count), 32'(vq[i].wc));
      if (vq[i].we) begin
        chk($sformatf("v%0d addr", i), wr_addr, vq[i].ad);
        chk($sformatf("v%0d data", i), wr_data, vq[i].wd);
      end
    end
    start      = 1'b0;
    byte_valid = 1'b0;

    // Backpressure: one-word load with 3 idle cycles between bytes (in LEN)
    @(negedge clk);
    base = wr_cnt;
    send(8'h01, 3); send(8'h24, 3); send(8'h10, 3);
    send(8'h00, 3); send(8'haa, 3); send(8'hde, 3);
    #1;
    chk("gap writes", 32'(wr_cnt - base), 1);
    chk("gap addr", last_a, 32'h0);
    chk("gap data", last_d, 32'h241000aa);
    chk("gap done", 32'(done), 1);
    chk("gap hold", 32'(cpu_hold), 0);
    chk("gap wc", 32'(word_count), 1);

    // Reset after the 6th byte of the two-word load
    @(negedge clk);
    pulse_start();
    send(8'h02, 0); send(8'h3c, 0); send(8'h11, 0);
    send(8'h40, 0); send(8'h00, 0); send(8'h26, 0);
    chk("pre-rst wc", 32'(word_count), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst ready", 32'(byte_ready), 0);
    chk("mid-rst wr_en", 32'(wr_en), 0);
    chk("mid-rst hold", 32'(cpu_hold), 1);
    chk("mid-rst done", 32'(done), 0);
    chk("mid-rst err", 32'(err), 0);
    chk("mid-rst wc", 32'(word_count), 0);
    chk("mid-rst data", wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_cnt;
    pulse_start();
    send_two_word(0);
    #1;
    chk("reload writes", 32'(wr_cnt - base), 2);
    chk("reload addr", last_a, 32'h4);
    chk("reload data", last_d, 32'h26310004);
    chk("reload done", 32'(done), 1);
    chk("reload err", 32'(err), 0);
    chk("reload hold", 32'(cpu_hold), 0);
    chk("reload wc", 32'(word_count), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Byte-stream writer that fills the CPU's instruction memory at boot, replacing the fixed initial program image.
- Accepts a framed byte stream (length, big-endian words, checksum) from the UART receiver over a valid/ready handshake.
- Issues one word write per received instruction into the instruction RAM's write port.
- Holds the CPU in reset until a complete, checksum-valid image has been written.

Parameters:
- ROM_SIZE, 32, instruction memory depth in words; the maximum accepted length.
- LEN_W, 8, width of the length byte and the word counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load
- byte_valid  in  1  input byte present
- byte_data  in  8  input byte
- byte_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  instruction RAM write strobe, one cycle per word
- wr_addr  out  32  byte address, word-aligned (index<<2)
- wr_data  out  32  instruction word
- cpu_hold  out  1  CPU reset request
- done  out  1  load finished with good checksum (level)
- err  out  1  load failed (level)
- word_count  out  8  words written so far in the current load

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low.
- Values in reset: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0, word_count=0, checksum=0.
- Handshake: a byte transfers in any cycle where byte_valid and byte_ready are both 1. Gaps in byte_valid are legal. byte_ready=1 only in LEN, DATA and CHK.
- FSM:
  - IDLE: on start, go to LEN. Clear word_count, checksum, done and err. Keep cpu_hold=1.
  - LEN: accept byte N.
    - N==0 or N>ROM_SIZE: go to ERR.
    - Otherwise latch N and go to DATA with byte index 0.
  - DATA: accept bytes MSB first into a 32-bit shift register. Add each byte to an 8-bit checksum, mod 256.
    - On the 4th byte of a word (accepted in cycle t), in cycle t+1: wr_en=1, wr_addr=word_count<<2, wr_data=assembled word. word_count increments in the same cycle.
    - byte_ready stays 1 during the write cycle. Back-to-back bytes are legal.
    - When the word that makes word_count==N is written, go to CHK.
  - CHK: accept one byte.
    - Byte equals checksum: go to DONE.
    - Otherwise: go to ERR.
  - DONE: done=1, cpu_hold=0 from the cycle after the checksum byte. byte_ready=0.
  - ERR: err=1, cpu_hold=1. byte_ready=0. wr_en is never asserted after entering ERR.
- start handling:
  - start in DONE or ERR restarts the load (goes to LEN) and reasserts cpu_hold.
  - start in LEN, DATA or CHK is ignored.
- Width rules:
  - wr_addr upper bits are zero.
  - The checksum covers data bytes only, not the length byte.
  - word_count never exceeds N.
- Reset mid-load: the load is abandoned immediately. Words already written stay in RAM; the loader does not clear them. cpu_hold=1.
- Simultaneous events: start together with byte_valid in IDLE starts the load, and that byte is not consumed (byte_ready was 0).

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, LEN, DATA, CHK, DONE, ERR);
  - ROM_SIZE, which the instruction memory also uses;
  - a word-to-byte-address shift constant of 2.
- One natural sub-module: byte_to_word_packer. It holds the shift register and the 2-bit byte counter, and emits word_valid plus the word. The FSM, counters and checksum stay in the top level.

Test Plan:
- Two-word load:
  - Stimulus: start, then bytes 02 3c 11 40 00 26 31 00 04 E8.
  - Required: writes (addr 0x0, data 0x3c114000) and (addr 0x4, data 0x26310004), each a single wr_en cycle one cycle after its 4th byte. done=1, err=0, cpu_hold falls after E8. word_count=2.
- Bad checksum:
  - Stimulus: same stream, final byte E9.
  - Required: both writes occur, err=1, done=0, cpu_hold stays 1.
- Illegal length:
  - Stimulus: length byte 00, then separately length byte 21 (33 > ROM_SIZE).
  - Required: ERR the cycle after each, no wr_en, cpu_hold=1.
- Backpressure gaps:
  - Stimulus: 1-word load (01 24 10 00 aa checksum DE) with byte_valid low for 3 cycles between each byte.
  - Required: single write (addr 0x0, data 0x241000aa), done=1.
- Reset mid-load:
  - Stimulus: after the 6th byte of the two-word load, assert rst_n=0 for 1 cycle.
  - Required: all outputs return to reset values asynchronously.
  - Follow-up: a subsequent start with a full stream completes normally.
- Start during busy:
  - Stimulus: pulse start while in DATA.
  - Required: ignored, load completes unchanged. Then start in DONE: done clears, cpu_hold=1, state LEN.
